image_sensor_emulator: RTL and testbench
========================================

// Module: image_sensor_emulator
// PURPOSE
//  Transmit side of the parallel image-sensor interface (PIXCLK/FV/LV/DOUT): generates sensor-
//  accurate frame/line timing and a deterministic test pattern, so the capture path and pixel-clock
//  recovery logic can run on the bench and in-system without a camera. Sits between the 50 MHz
//  system clock domain and the camera-input pins (via a board mux), driven by the housekeeping CPU.
// PARAMETERS
//  IMAGE_WIDTH   2592  active pixels per row (LV high, one pixel per PIXCLK)
//  IMAGE_HEIGHT  1944  active rows per frame
//  HB            450   horizontal blanking, PIXCLKs, FV high LV low, between rows (not after last row)
//  VB            9     vertical blanking, rows of (IMAGE_WIDTH+HB) PIXCLKs, FV low, after each frame
//  FV_LEAD       2     PIXCLKs FV is high before first LV of a frame (>=1)
//  CLK_DIV_HALF  4     clk cycles per PIXCLK half-period (50 MHz/8 = 6.25 MHz); >=2
//  DATA_W        12    pixel width
// PORTS
//  clk          in  1       system clock, 50 MHz
//  reset        in  1       asynchronous, active-high
//  run          in  1       level: stream frames continuously while high
//  trigger      in  1       1-clk pulse: emit exactly one frame (snapshot) when idle
//  pattern_sel  in  2       0 col ramp, 1 row ramp, 2 (row+col) mod 2^DATA_W, 3 constant 'hA5A
//  pixclk       out 1       emulated sensor pixel clock, free-running after reset
//  fv           out 1       frame valid
//  lv           out 1       line valid
//  dout         out DATA_W  pixel data
//  busy         out 1       high from frame start through end of VBLANK
//  frame_done   out 1       1-clk pulse on the clk cycle fv falls
//  frame_count  out 16      frames completed, wraps 16'hFFFF->0
// BEHAVIOUR
//  - Reset (async): pixclk=0, fv=0, lv=0, dout=0, busy=0, frame_done=0, frame_count=0, state=IDLE.
//  - pixclk toggles every CLK_DIV_HALF clk cycles. fv/lv/dout update only on the clk edge where
//    pixclk goes 1->0 (sensor launches on falling edge); all are stable at every pixclk rise.
//    Internal 'fall strobe' = that cycle; all counters/FSM advance on the fall strobe only.
//  - FSM: IDLE -> LEAD (FV_LEAD pixclks, fv=1 lv=0) -> ACTIVE (IMAGE_WIDTH pixclks, fv=1 lv=1)
//    -> HBLANK (HB pixclks, fv=1 lv=0) -> ACTIVE ... ; after ACTIVE of row IMAGE_HEIGHT-1 fv and
//    lv fall together -> VBLANK (VB*(IMAGE_WIDTH+HB) pixclks, fv=0) -> LEAD if run, else IDLE.
//  - Start: in IDLE, at fall strobe, if run=1 or a latched trigger -> LEAD. trigger is latched
//    (sticky) until consumed; triggers arriving while busy are dropped. run and trigger together:
//    one start, trigger latch cleared.
//  - run deasserted mid-frame: current frame and its VBLANK complete, then IDLE. Never truncate.
//  - Frame period (pixclks) = FV_LEAD + H*W + (H-1)*HB + VB*(W+HB).
//  - dout = pattern(row,col) while lv=1, 0 otherwise; pattern_sel sampled at LEAD entry, held for
//    the frame. Ramps truncate to DATA_W bits (col 4096 -> 0).
//  - Counters: col sized $clog2(max(IMAGE_WIDTH,HB,VB*(IMAGE_WIDTH+HB))+1), row
//    $clog2(IMAGE_HEIGHT+1); both cleared at LEAD entry, no wrap within a frame.
//  - frame_count increments with frame_done. busy rises on the LEAD-entry clk, falls on the
//    VBLANK-exit clk (stays high across back-to-back frames).
// STRUCTURE
//  - Shared package cam_if_pkg: sensor_state_t enum {IDLE,LEAD,ACTIVE,HBLANK,VBLANK}, pattern
//    codes PAT_COL/PAT_ROW/PAT_DIAG/PAT_CONST, PAT_CONST_VALUE='hA5A, default timing constants
//    shared with the capture side.
//  - One sub-module: pixclk_divider (counter+toggle, outputs pixclk and fall strobe). FSM, pattern
//    mux and output regs stay in this module.
// TESTING (bench params W=4 H=2 HB=3 VB=2 FV_LEAD=1 CLK_DIV_HALF=2)
//  1 reset mid-stream -> all outputs 0 same cycle; after release pixclk period = 4 clk, 50% duty.
//  2 trigger pulse, pattern_sel=0 -> one frame: fv high 1+8+3=12 pixclks, two LV bursts of 4,
//    dout 0,1,2,3 each row, frame_done once, frame_count=1, busy falls 26 pixclks after rise.
//  3 run=1 pattern_sel=2 for 3 frames -> fv period 26 pixclks, row1 dout 1,2,3,4, busy never
//    drops, frame_count=3; drop run in frame 3 -> frame finishes, then IDLE.
//  4 trigger while busy -> ignored (exactly one frame); run+trigger same cycle -> one start.
//  5 change pattern_sel mid-frame 0->3 -> current frame stays ramp, next frame all 'hA5A.
//  6 checker on every pixclk rise: fv/lv/dout stable vs previous fall; lv=1 implies fv=1.

Source files
------------

// File: rtl/cam_if_pkg.sv
// Shared definitions for the parallel image-sensor interface (emulator and capture side).
// Contents: FSM state enum, test-pattern codes, the constant-pattern value, default sensor
// timing constants and a small helper for sizing counters.
package cam_if_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEAD   = 3'd1,
    ACTIVE = 3'd2,
    HBLANK = 3'd3,
    VBLANK = 3'd4
  } sensor_state_t;

  typedef enum logic [1:0] {
    PAT_COL   = 2'd0,
    PAT_ROW   = 2'd1,
    PAT_DIAG  = 2'd2,
    PAT_CONST = 2'd3
  } pattern_t;

  localparam logic [11:0] PAT_CONST_VALUE = 12'hA5A;

  // Default timing of the emulated 5 MP sensor.
  localparam int unsigned DEF_IMAGE_WIDTH  = 2592;
  localparam int unsigned DEF_IMAGE_HEIGHT = 1944;
  localparam int unsigned DEF_HB           = 450;
  localparam int unsigned DEF_VB           = 9;
  localparam int unsigned DEF_FV_LEAD      = 2;
  localparam int unsigned DEF_CLK_DIV_HALF = 4;
  localparam int unsigned DEF_DATA_W       = 12;

  // Largest of three values, used for counter sizing.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/image_sensor_emulator_if.sv
// Bundle of the control and sensor-pin signals of the image-sensor emulator.
// master: the emulator (takes run/trigger/pattern_sel, drives pixclk/fv/lv/dout and status).
// slave : the controller / capture side (the opposite directions).
interface image_sensor_emulator_if #(
  parameter int unsigned DATA_W = 12
);
  logic              run;
  logic              trigger;
  logic [1:0]        pattern_sel;
  logic              pixclk;
  logic              fv;
  logic              lv;
  logic [DATA_W-1:0] dout;
  logic              busy;
  logic              frame_done;
  logic [15:0]       frame_count;

  modport master (
    input  run, trigger, pattern_sel,
    output pixclk, fv, lv, dout, busy, frame_done, frame_count
  );

  modport slave (
    output run, trigger, pattern_sel,
    input  pixclk, fv, lv, dout, busy, frame_done, frame_count
  );
endinterface

// File: rtl/pixclk_divider.sv
// Pixel-clock generator: divides clk so pixclk toggles every CLK_DIV_HALF clk cycles.
// Ports: clk, reset (async, active-high) in; pixclk (registered, 0 in reset) out;
//        fall_stb_c (combinational) out, high in the clk cycle whose closing edge drops pixclk.
module pixclk_divider #(
  parameter int unsigned CLK_DIV_HALF = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pixclk,
  output logic fall_stb_c
);
  localparam int unsigned CNT_W = $clog2(CLK_DIV_HALF);

  logic [CNT_W-1:0] cnt;
  logic             wrap_c;

  assign wrap_c     = (cnt == CNT_W'(CLK_DIV_HALF - 1));
  assign fall_stb_c = wrap_c & pixclk;

  // Half-period counter and toggle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      pixclk <= 1'b0;
    end else if (wrap_c) begin
      cnt    <= '0;
      pixclk <= ~pixclk;
    end else begin
      cnt    <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/image_sensor_emulator.sv
// Transmit side of a parallel image-sensor interface: emits sensor-accurate FV/LV timing and
// a deterministic test pattern on DOUT, launched on the falling edge of the emulated PIXCLK.
// Ports: clk, reset (async, active-high); bus (master modport):
//   run (stream continuously), trigger (one-shot frame), pattern_sel in;
//   pixclk, fv, lv, dout, busy, frame_done (1-clk pulse as fv falls), frame_count out.
module image_sensor_emulator
  import cam_if_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int unsigned IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int unsigned HB           = DEF_HB,
  parameter int unsigned VB           = DEF_VB,
  parameter int unsigned FV_LEAD      = DEF_FV_LEAD,
  parameter int unsigned CLK_DIV_HALF = DEF_CLK_DIV_HALF,
  parameter int unsigned DATA_W       = DEF_DATA_W
) (
  input logic                     clk,
  input logic                     reset,
  image_sensor_emulator_if.master bus
);
  localparam int unsigned VB_LEN = VB * (IMAGE_WIDTH + HB);
  localparam int unsigned COL_W  = $clog2(max3(IMAGE_WIDTH, HB, VB_LEN) + 1);
  localparam int unsigned ROW_W  = $clog2(IMAGE_HEIGHT + 1);

  sensor_state_t     state;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  pattern_t          pat;
  logic              trig_latch;
  logic              fv_q;
  logic              lv_q;
  logic [DATA_W-1:0] dout_q;
  logic              busy_q;
  logic              frame_done_q;
  logic [15:0]       frame_count_q;

  logic              pixclk;
  logic              fall_stb_c;
  logic              lead_go_c;

  pixclk_divider #(
    .CLK_DIV_HALF(CLK_DIV_HALF)
  ) u_pixclk_divider (
    .clk       (clk),
    .reset     (reset),
    .pixclk    (pixclk),
    .fall_stb_c(fall_stb_c)
  );

  // Frame start: from IDLE on run or a pending trigger, or chained at VBLANK end while run holds.
  assign lead_go_c = ((state == IDLE) && (bus.run || bus.trigger || trig_latch)) ||
                     ((state == VBLANK) && (col == COL_W'(VB_LEN - 1)) && bus.run);

  // Test pattern value for one pixel; ramps wrap at 2^DATA_W.
  function automatic logic [DATA_W-1:0] pattern_value(input pattern_t p,
                                                      input logic [ROW_W-1:0] r,
                                                      input logic [COL_W-1:0] c);
    logic [DATA_W-1:0] v;
    v = DATA_W'(c);
    case (p)
      PAT_COL:   v = DATA_W'(c);
      PAT_ROW:   v = DATA_W'(r);
      PAT_DIAG:  v = DATA_W'(c) + DATA_W'(r);
      PAT_CONST: v = DATA_W'(PAT_CONST_VALUE);
      default:   v = DATA_W'(c);
    endcase
    return v;
  endfunction

  // Frame FSM with registered pins; everything but the trigger latch moves on the fall strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      col           <= '0;
      row           <= '0;
      pat           <= PAT_COL;
      trig_latch    <= 1'b0;
      fv_q          <= 1'b0;
      lv_q          <= 1'b0;
      dout_q        <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_done_q <= 1'b0;

      // Triggers are remembered only while idle; any frame start consumes them.
      if (fall_stb_c && lead_go_c) begin
        trig_latch <= 1'b0;
      end else if (bus.trigger && (state == IDLE)) begin
        trig_latch <= 1'b1;
      end

      if (fall_stb_c) begin
        if (lead_go_c) begin
          state  <= LEAD;
          col    <= '0;
          row    <= '0;
          pat    <= pattern_t'(bus.pattern_sel);
          fv_q   <= 1'b1;
          lv_q   <= 1'b0;
          dout_q <= '0;
          busy_q <= 1'b1;
        end else begin
          case (state)
            IDLE: ;
            LEAD: begin
              if (col == COL_W'(FV_LEAD - 1)) begin
                state  <= ACTIVE;
                col    <= '0;
                lv_q   <= 1'b1;
                dout_q <= pattern_value(pat, row, '0);
              end else begin
                col <= col + COL_W'(1);
              end
            end
            ACTIVE: begin
              if (col == COL_W'(IMAGE_WIDTH - 1)) begin
                col    <= '0;
                lv_q   <= 1'b0;
                dout_q <= '0;
                if (row == ROW_W'(IMAGE_HEIGHT - 1)) begin
                  // Last row: fv drops with lv, no trailing HBLANK.
                  state         <= VBLANK;
                  fv_q          <= 1'b0;
                  frame_done_q  <= 1'b1;
                  frame_count_q <= frame_count_q + 16'd1;
                end else begin
                  state <= HBLANK;
                end
              end else begin
                col    <= col + COL_W'(1);
                dout_q <= pattern_value(pat, row, col + COL_W'(1));
              end
            end
            HBLANK: begin
              if (col == COL_W'(HB - 1)) begin
                state  <= ACTIVE;
                col    <= '0;
                row    <= row + ROW_W'(1);
                lv_q   <= 1'b1;
                dout_q <= pattern_value(pat, row + ROW_W'(1), '0);
              end else begin
                col <= col + COL_W'(1);
              end
            end
            VBLANK: begin
              if (col == COL_W'(VB_LEN - 1)) begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end else begin
                col <= col + COL_W'(1);
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.pixclk      = pixclk;
  assign bus.fv          = fv_q;
  assign bus.lv          = lv_q;
  assign bus.dout        = dout_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_count = frame_count_q;
endmodule

// File: tb/tb_image_sensor_emulator.sv
// Self-checking bench for image_sensor_emulator with a small sensor geometry
// (W=4, H=2, HB=3, VB=2, FV_LEAD=1, CLK_DIV_HALF=2). Every pixclk rise is captured; captured
// streams are compared against a per-pixclk frame model computed from the timing rules.
module tb_image_sensor_emulator;
  localparam int W   = 4;
  localparam int H   = 2;
  localparam int HB  = 3;
  localparam int VB  = 2;
  localparam int FVL = 1;
  localparam int CDH = 2;
  localparam int DW  = 12;
  localparam int PER = FVL + H * W + (H - 1) * HB + VB * (W + HB);
  localparam int FRAME_CLK = PER * 2 * CDH;

  typedef struct packed {
    logic          fv;
    logic          lv;
    logic [DW-1:0] dout;
    logic          busy;
  } samp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  image_sensor_emulator_if #(.DATA_W(DW)) bus ();

  image_sensor_emulator #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .HB          (HB),
    .VB          (VB),
    .FV_LEAD     (FVL),
    .CLK_DIV_HALF(CDH),
    .DATA_W      (DW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial forever #5 clk = ~clk;

  samp_t rise_q[$];
  int    exp_pats[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    fd_count = 0;
  int    exp_fc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pattern value from the definition of each test pattern.
  function automatic logic [DW-1:0] pat(input int p, input int r, input int c);
    case (p)
      0:       return DW'(c % (1 << DW));
      1:       return DW'(r % (1 << DW));
      2:       return DW'((r + c) % (1 << DW));
      default: return DW'(12'hA5A);
    endcase
  endfunction

  // Expected pin state at the t-th pixclk rise of a frame (t=0 is the first FV-high pixclk).
  function automatic samp_t model(input int p, input int t);
    samp_t s;
    int u;
    s = '0;
    s.busy = 1'b1;
    if (t < FVL) begin
      s.fv = 1'b1;
    end else begin
      u = t - FVL;
      if (u < H * W + (H - 1) * HB) begin
        s.fv = 1'b1;
        if ((u % (W + HB)) < W) begin
          s.lv   = 1'b1;
          s.dout = pat(p, u / (W + HB), u % (W + HB));
        end
      end
    end
    return s;
  endfunction

  // Pin monitor: stability at pixclk rise, lv implies fv, frame_done coincides with fv fall.
  initial begin : monitor
    logic pix_prev, fv_prev, snap_valid;
    logic [DW+1:0] snap;
    samp_t s;
    pix_prev = 1'b0;
    fv_prev = 1'b0;
    snap_valid = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        snap_valid = 1'b0;
      end else begin
        if (bus.pixclk && !pix_prev) begin
          if (snap_valid)
            chk("rise_stable", 32'({bus.fv, bus.lv, bus.dout}), 32'(snap));
          chk("lv_implies_fv", 32'(bus.lv & ~bus.fv), 32'(0));
          s = '{fv: bus.fv, lv: bus.lv, dout: bus.dout, busy: bus.busy};
          rise_q.push_back(s);
        end
        if (!bus.pixclk && pix_prev) begin
          snap = {bus.fv, bus.lv, bus.dout};
          snap_valid = 1'b1;
        end
        if (bus.frame_done) begin
          fd_count++;
          chk("frame_done_on_fv_fall", 32'({fv_prev, bus.fv}), 32'(2'b10));
        end
      end
      pix_prev = bus.pixclk;
      fv_prev = bus.fv;
    end
  end

  task automatic wait_busy(input logic lvl, input int max_clk, input string tag);
    int k = 0;
    while (bus.busy !== lvl && k < max_clk) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(bus.busy), 32'(lvl));
  endtask

  task automatic wait_fv(input logic lvl, input int max_clk, input string tag);
    int k = 0;
    while (bus.fv !== lvl && k < max_clk) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(bus.fv), 32'(lvl));
  endtask

  task automatic wait_fd(input int target, input int max_clk, input string tag);
    int k = 0;
    while (fd_count < target && k < max_clk) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(fd_count), 32'(target));
  endtask

  task automatic pulse_trigger();
    bus.trigger = 1'b1;
    @(negedge clk);
    bus.trigger = 1'b0;
  endtask

  task automatic start_case();
    rise_q.delete();
    exp_pats.delete();
  endtask

  // Compare captured rises: idle, then exp_pats.size() back-to-back frames, then idle again.
  task automatic check_frames(input string tag);
    int first = -1;
    int pre_bad = 0;
    int nf = exp_pats.size();
    int idx;
    int post_n;
    bit short_q = 1'b0;
    foreach (rise_q[i]) if (first < 0 && rise_q[i].fv) first = i;
    chk({tag, "_fv_seen"}, 32'(first >= 0), 32'(1));
    if (first < 0) return;
    for (int i = 0; i < first; i++) if (rise_q[i].fv || rise_q[i].busy) pre_bad++;
    chk({tag, "_idle_before"}, 32'(pre_bad), 32'(0));
    for (int f = 0; f < nf && !short_q; f++) begin
      for (int t = 0; t < PER && !short_q; t++) begin
        idx = first + f * PER + t;
        if (idx >= rise_q.size()) begin
          short_q = 1'b1;
          chk({tag, "_enough_pixclks"}, 32'(rise_q.size()), 32'(first + nf * PER));
        end else begin
          chk($sformatf("%s_f%0d_t%0d", tag, f, t), 32'(rise_q[idx]),
              32'(model(exp_pats[f], t)));
        end
      end
    end
    if (short_q) return;
    post_n = rise_q.size() - (first + nf * PER);
    chk({tag, "_idle_after_len"}, 32'(post_n >= 8), 32'(1));
    for (int i = first + nf * PER; i < rise_q.size(); i++)
      chk($sformatf("%s_idle_after_%0d", tag, i - first - nf * PER), 32'(rise_q[i]), 32'(0));
  endtask

  initial begin : stimulus
    int fd0;
    int n_fv;
    int n_lv;
    bus.run = 1'b0;
    bus.trigger = 1'b0;
    bus.pattern_sel = 2'd0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pixclk", 32'(bus.pixclk), 32'(0));
    chk("rst_fv", 32'(bus.fv), 32'(0));
    chk("rst_lv", 32'(bus.lv), 32'(0));
    chk("rst_dout", 32'(bus.dout), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_frame_done", 32'(bus.frame_done), 32'(0));
    chk("rst_frame_count", 32'(bus.frame_count), 32'(0));
    reset = 1'b0;

    // 1: asynchronous reset in the middle of a frame, then pixclk phase/duty after release
    bus.run = 1'b1;
    wait_busy(1'b1, 40, "t1_busy_rise");
    repeat (20) @(negedge clk);
    chk("t1_fv_midframe", 32'(bus.fv), 32'(1));
    #2 reset = 1'b1;
    #1;
    chk("t1_async_pixclk", 32'(bus.pixclk), 32'(0));
    chk("t1_async_fv", 32'(bus.fv), 32'(0));
    chk("t1_async_lv", 32'(bus.lv), 32'(0));
    chk("t1_async_dout", 32'(bus.dout), 32'(0));
    chk("t1_async_busy", 32'(bus.busy), 32'(0));
    chk("t1_async_frame_done", 32'(bus.frame_done), 32'(0));
    chk("t1_async_frame_count", 32'(bus.frame_count), 32'(0));
    bus.run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("t1_pixclk_clk%0d", k), 32'(bus.pixclk), 32'((k / CDH) % 2));
    end

    // 2: single triggered frame, column ramp
    start_case();
    bus.pattern_sel = 2'd0;
    fd0 = fd_count;
    pulse_trigger();
    wait_busy(1'b1, 40, "t2_busy_rise");
    wait_busy(1'b0, FRAME_CLK + 40, "t2_busy_fall");
    repeat (60) @(negedge clk);
    exp_pats.push_back(0);
    exp_fc += 1;
    check_frames("t2");
    n_fv = 0;
    n_lv = 0;
    foreach (rise_q[i]) begin
      n_fv += int'(rise_q[i].fv);
      n_lv += int'(rise_q[i].lv);
    end
    chk("t2_fv_pixclks", 32'(n_fv), 32'(FVL + H * W + (H - 1) * HB));
    chk("t2_lv_pixclks", 32'(n_lv), 32'(H * W));
    chk("t2_frame_done_pulses", 32'(fd_count - fd0), 32'(1));
    chk("t2_frame_count", 32'(bus.frame_count), 32'(exp_fc));

    // 3: continuous run, diagonal pattern, run dropped early in the third frame
    start_case();
    bus.pattern_sel = 2'd2;
    fd0 = fd_count;
    bus.run = 1'b1;
    wait_busy(1'b1, 40, "t3_busy_rise");
    wait_fd(fd0 + 2, 3 * FRAME_CLK, "t3_two_frames");
    wait_fv(1'b1, 2 * FRAME_CLK, "t3_third_fv");
    repeat ($urandom_range(1, 3)) @(negedge clk);
    bus.run = 1'b0;
    wait_busy(1'b0, 2 * FRAME_CLK, "t3_busy_fall");
    repeat (60) @(negedge clk);
    repeat (3) exp_pats.push_back(2);
    exp_fc += 3;
    check_frames("t3");
    chk("t3_frame_done_pulses", 32'(fd_count - fd0), 32'(3));
    chk("t3_frame_count", 32'(bus.frame_count), 32'(exp_fc));

    // 4a: triggers while busy (active and VBLANK) are dropped
    start_case();
    bus.pattern_sel = 2'd1;
    fd0 = fd_count;
    pulse_trigger();
    wait_busy(1'b1, 40, "t4a_busy_rise");
    repeat ($urandom_range(6, 14)) @(negedge clk);
    pulse_trigger();
    wait_fv(1'b0, FRAME_CLK, "t4a_fv_fall");
    repeat ($urandom_range(1, 20)) @(negedge clk);
    pulse_trigger();
    wait_busy(1'b0, FRAME_CLK + 40, "t4a_busy_fall");
    repeat (60) @(negedge clk);
    exp_pats.push_back(1);
    exp_fc += 1;
    check_frames("t4a");
    chk("t4a_frame_count", 32'(bus.frame_count), 32'(exp_fc));

    // 4b: run and trigger together for one pixclk period give exactly one frame
    start_case();
    bus.pattern_sel = 2'd3;
    bus.run = 1'b1;
    bus.trigger = 1'b1;
    repeat (2 * CDH) @(negedge clk);
    bus.run = 1'b0;
    bus.trigger = 1'b0;
    wait_busy(1'b1, 40, "t4b_busy_rise");
    wait_busy(1'b0, FRAME_CLK + 40, "t4b_busy_fall");
    repeat (60) @(negedge clk);
    exp_pats.push_back(3);
    exp_fc += 1;
    check_frames("t4b");
    chk("t4b_frame_count", 32'(bus.frame_count), 32'(exp_fc));

    // 5: pattern_sel changed mid-frame only affects the next frame
    start_case();
    bus.pattern_sel = 2'd0;
    fd0 = fd_count;
    bus.run = 1'b1;
    wait_busy(1'b1, 40, "t5_busy_rise");
    repeat ($urandom_range(8, 30)) @(negedge clk);
    bus.pattern_sel = 2'd3;
    wait_fd(fd0 + 1, 2 * FRAME_CLK, "t5_first_frame");
    wait_fv(1'b1, 2 * FRAME_CLK, "t5_second_fv");
    bus.run = 1'b0;
    wait_busy(1'b0, 2 * FRAME_CLK, "t5_busy_fall");
    repeat (60) @(negedge clk);
    exp_pats.push_back(0);
    exp_pats.push_back(3);
    exp_fc += 2;
    check_frames("t5");
    chk("t5_frame_done_pulses", 32'(fd_count - fd0), 32'(2));
    chk("t5_frame_count", 32'(bus.frame_count), 32'(exp_fc));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
